// File: rtl/correlator_scheduler_pkg.sv
// Shared constants and state encoding for the correlator scheduler.
package correlator_scheduler_pkg;
  localparam int LEN_W = 13;
  localparam logic [LEN_W-1:0] DEF_WIN = 13'h0800;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_CLEAR = 2'd1;
  localparam state_t ST_RUN   = 2'd2;
  localparam state_t ST_DUMP  = 2'd3;
endpackage

// File: rtl/correlator_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after last_owner.
module rr_arbiter
  import correlator_scheduler_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last_owner,
  output logic [N_REQ-1:0] grant
);
  int idx;

  // Walk from lowest to highest priority so the highest-priority hit is written last.
  always_comb begin
    grant = '0;
    idx   = 0;
    for (int i = N_REQ; i >= 1; i--) begin
      idx = (int'(last_owner) + i) % N_REQ;
      if (req[idx]) grant = N_REQ'(1) << idx;
    end
  end
endmodule

// File: rtl/correlator_scheduler.sv
// Time-shares one correlator among N_REQ requesters: grant, clear, count a window, dump.
module correlator_scheduler #(
  parameter int N_REQ = 4,
  parameter int LEN_W = correlator_scheduler_pkg::LEN_W,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [LEN_W-1:0] win_len,
  input  logic             sample_vld,
  input  logic             result_ack,
  input  logic             abort,
  output logic [N_REQ-1:0] grant,
  output logic             corr_rst,
  output logic             corr_en,
  output logic             done_stb,
  output logic [IDW-1:0]   done_id,
  output logic             busy
);
  import correlator_scheduler_pkg::*;

  state_t           state;
  logic [IDW-1:0]   last_owner;
  logic [LEN_W-1:0] len;
  logic [LEN_W:0]   cnt;
  logic [LEN_W:0]   cnt_nxt;
  logic [N_REQ-1:0] arb_gnt;
  logic [IDW-1:0]   gnt_id;

  rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req       (req),
    .last_owner(last_owner),
    .grant     (arb_gnt)
  );

  always_comb begin
    gnt_id = '0;
    for (int i = 0; i < N_REQ; i++)
      if (arb_gnt[i]) gnt_id = IDW'(i);
  end

  assign cnt_nxt  = cnt + {{LEN_W{1'b0}}, 1'b1};
  assign corr_rst = (state == ST_CLEAR);
  assign corr_en  = (state == ST_RUN);
  assign done_stb = (state == ST_DUMP);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      grant      <= '0;
      done_id    <= '0;
      last_owner <= IDW'(N_REQ - 1);
      len        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|req) begin
          grant   <= arb_gnt;
          done_id <= gnt_id;
          len     <= (win_len == '0) ? LEN_W'(DEF_WIN) : win_len;
          cnt     <= '0;
          state   <= ST_CLEAR;
        end
        ST_CLEAR: begin
          cnt <= '0;
          if (abort) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_owner <= done_id;
          end else begin
            state <= ST_RUN;
          end
        end
        // Abort outranks a window-completing sample in the same cycle.
        ST_RUN: if (abort) begin
          state      <= ST_IDLE;
          grant      <= '0;
          last_owner <= done_id;
        end else if (sample_vld) begin
          cnt <= cnt_nxt;
          if (cnt_nxt == {1'b0, len}) state <= ST_DUMP;
        end
        ST_DUMP: if (result_ack) begin
          state      <= ST_IDLE;
          grant      <= '0;
          last_owner <= done_id;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_correlator_scheduler.sv
// Randomized and directed bench for correlator_scheduler against a window-level reference model.
module tb_correlator_scheduler;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [12:0] win_len;
  logic        sample_vld, result_ack, abort;
  logic [3:0]  grant;
  logic        corr_rst, corr_en, done_stb, busy;
  logic [1:0]  done_id;

  correlator_scheduler #(.N_REQ(N), .LEN_W(13)) dut (
    .clk(clk), .rst(rst), .req(req), .win_len(win_len), .sample_vld(sample_vld),
    .result_ack(result_ack), .abort(abort), .grant(grant), .corr_rst(corr_rst),
    .corr_en(corr_en), .done_stb(done_stb), .done_id(done_id), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: owner (-1 = nobody), cycles since grant, samples taken, window length, result pending.
  int m_owner, m_last, m_age, m_samples, m_len, m_granted;
  bit m_done;

  function automatic void m_reset();
    m_owner = -1; m_last = N - 1; m_age = 0; m_samples = 0; m_done = 0; m_granted = -1;
  endfunction

  function automatic void m_release();
    m_last = m_owner; m_owner = -1; m_done = 0;
  endfunction

  function automatic void m_step();
    bit found;
    int c;
    m_granted = -1;
    found = 0;
    if (m_owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        c = (m_last + k) % N;
        if (!found && req[c]) begin found = 1; m_owner = c; end
      end
      if (found) begin
        m_len = (win_len == 0) ? 2048 : int'(win_len);
        m_age = 0; m_samples = 0; m_done = 0; m_granted = m_owner;
      end
    end else if (m_age == 0) begin
      if (abort) m_release(); else m_age = 1;
    end else if (!m_done) begin
      if (abort) m_release();
      else if (sample_vld) begin
        m_samples++;
        if (m_samples == m_len) m_done = 1;
      end
    end else if (result_ack) m_release();
  endfunction

  task automatic compare();
    chk("grant", grant, (m_owner < 0) ? 0 : (1 << m_owner));
    chk("busy", busy, m_owner >= 0);
    chk("corr_rst", corr_rst, m_owner >= 0 && m_age == 0);
    chk("corr_en", corr_en, m_owner >= 0 && m_age > 0 && !m_done);
    chk("done_stb", done_stb, m_done);
    if (m_done) chk("done_id", done_id, m_owner);
  endtask

  task automatic tick(input logic [3:0] r, input logic [12:0] wl, input logic sv,
                      input logic ack, input logic ab);
    req = r; win_len = wl; sample_vld = sv; result_ack = ack; abort = ab;
    @(posedge clk);
    m_step();
    @(negedge clk);
    compare();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    compare();
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && busy; i++) tick(4'h0, 13'd2, 1'b1, 1'b1, 1'b0);
    chk("drain_idle", busy, 1'b0);
  endtask

  int en_cnt, rst_cnt, n;
  logic [3:0] got_g [5];
  logic [3:0] exp_g [5];
  logic [3:0] pend;
  logic [4:0] sv_pat;

  initial begin
    rst = 1'b1; req = '0; win_len = '0; sample_vld = 0; result_ack = 0; abort = 0;
    m_reset();
    @(negedge clk);
    compare();
    chk("rst_done_id", done_id, 2'd0);
    @(negedge clk);
    rst = 1'b0;

    // Default-length window from requester 0
    en_cnt = 0; rst_cnt = 0;
    for (int i = 0; i < 2300 && !done_stb; i++) begin
      tick(busy ? 4'h0 : 4'h1, 13'd0, 1'b1, 1'b0, 1'b0);
      en_cnt += int'(corr_en); rst_cnt += int'(corr_rst);
    end
    chk("s1_en_cycles", en_cnt, 2048);
    chk("s1_rst_cycles", rst_cnt, 1);
    chk("s1_done", done_stb, 1'b1);
    chk("s1_done_id", done_id, 2'd0);
    chk("s1_grant", grant, 4'b0001);
    tick(4'h0, 13'd0, 1'b0, 1'b1, 1'b0);
    chk("s1_idle", busy, 1'b0);

    // Round-robin sweep with all requesters asserted
    do_reset();
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    n = 0;
    for (int i = 0; i < 200 && n < 5; i++) begin
      tick(4'hF, 13'd4, 1'b1, done_stb, 1'b0);
      if (corr_rst) begin got_g[n] = grant; n++; end
    end
    chk("rr_count", n, 5);
    for (int k = 0; k < 5; k++) chk($sformatf("rr_grant%0d", k), got_g[k], exp_g[k]);
    drain();

    // Sparse samples: DUMP only after the third valid
    tick(4'h1, 13'd3, 1'b0, 1'b0, 1'b0);
    chk("s3_clear", corr_rst, 1'b1);
    tick(4'h0, 13'd3, 1'b0, 1'b0, 1'b0);
    sv_pat = 5'b10101;
    for (int k = 0; k < 5; k++) begin
      tick(4'h0, 13'd3, sv_pat[k], 1'b0, 1'b0);
      chk($sformatf("s3_done%0d", k), done_stb, k == 4);
    end
    tick(4'h0, 13'd3, 1'b0, 1'b1, 1'b0);

    // Abort on the second RUN cycle, then arbitration moves on
    tick(4'hF, 13'd5, 1'b0, 1'b0, 1'b0);
    chk("s4_grant", grant, 4'b0010);
    tick(4'h0, 13'd5, 1'b1, 1'b0, 1'b0);
    tick(4'h0, 13'd5, 1'b1, 1'b0, 1'b0);
    tick(4'h0, 13'd5, 1'b1, 1'b0, 1'b1);
    chk("s4_abort_idle", busy, 1'b0);
    chk("s4_abort_grant", grant, 4'b0000);
    chk("s4_abort_done", done_stb, 1'b0);
    tick(4'hF, 13'd2, 1'b1, 1'b0, 1'b0);
    chk("s4_next_grant", grant, 4'b0100);
    drain();

    // Result held without acknowledge
    tick(4'h8, 13'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10 && !done_stb; i++) tick(4'h0, 13'd2, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(4'h0, 13'd2, 1'b1, 1'b0, 1'b0);
      chk("s5_hold_done", done_stb, 1'b1);
      chk("s5_hold_grant", grant, 4'b1000);
      chk("s5_hold_id", done_id, 2'd3);
    end
    tick(4'h0, 13'd2, 1'b0, 1'b1, 1'b0);
    chk("s5_ack_idle", busy, 1'b0);

    // Asynchronous reset mid-window
    tick(4'h1, 13'd20, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) tick(4'h1, 13'd20, 1'b1, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("s6_rst_grant", grant, 4'b0000);
    chk("s6_rst_corr_rst", corr_rst, 1'b0);
    chk("s6_rst_corr_en", corr_en, 1'b0);
    chk("s6_rst_done", done_stb, 1'b0);
    chk("s6_rst_id", done_id, 2'd0);
    chk("s6_rst_busy", busy, 1'b0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
    compare();
    tick(4'h1, 13'd20, 1'b1, 1'b0, 1'b0);
    chk("s6_regrant", grant, 4'b0001);
    chk("s6_clear", corr_rst, 1'b1);
    drain();

    // Randomized traffic
    do_reset();
    pend = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) if ($urandom_range(0, 7) == 0) pend[k] = 1'b1;
      tick(pend, 13'($urandom_range(0, 40) == 0 ? 0 : $urandom_range(1, 12)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 31) == 0);
      if (m_granted >= 0) pend[m_granted] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/correlator_scheduler.md
CORRELATOR_SCHEDULER -- requirements
Module: correlator_scheduler

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the correlator.
REQ-002 Parameter LEN_W, default 13: window-length width; default window length 13'h0800.
REQ-003 clk  in  1  sole clock; all state changes on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 req  in  N_REQ  per-requester capture request, level, held until grant.
REQ-006 win_len  in  LEN_W  window length in valid samples, sampled at grant.
REQ-007 sample_vld  in  1  correlator accepted one sample this cycle.
REQ-008 result_ack  in  1  consumer has taken the correlator result.
REQ-009 abort  in  1  synchronous abort of the current window.
REQ-010 grant  out  N_REQ  one-hot owner of the correlator, all-zero when idle.
REQ-011 corr_rst  out  1  one-cycle clear pulse to the correlator accumulators.
REQ-012 corr_en  out  1  correlator accumulate enable.
REQ-013 done_stb  out  1  result-ready level, held until acknowledged.
REQ-014 done_id  out  clog2(N_REQ)  index of the owning requester.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 FSM states SHALL be IDLE, CLEAR, RUN, DUMP.
REQ-017 IDLE: if any req bit set, SHALL grant in round-robin order starting at index (last_owner+1) mod N_REQ, latch win_len, and go to CLEAR; else stay.
REQ-018 win_len==0 at grant SHALL be replaced by 13'h0800.
REQ-019 CLEAR SHALL last exactly one cycle with corr_rst=1, corr_en=0, sample counter cleared, then go to RUN.
REQ-020 RUN: corr_en=1; counter SHALL increment on each sample_vld; transition to DUMP in the cycle after the valid sample that makes count+1 equal the latched length.
REQ-021 Counter width SHALL be LEN_W+1 bits; no wrap is reachable within one window.
REQ-022 DUMP: corr_en=0, done_stb=1, done_id=owner; on result_ack SHALL drop grant, record last_owner, go to IDLE.
REQ-023 grant SHALL stay constant from CLEAR through DUMP regardless of req deassertion.
REQ-024 A new request arriving during a window SHALL be arbitrated only on return to IDLE; minimum gap between windows is one IDLE cycle.
REQ-025 abort in CLEAR or RUN SHALL go to IDLE next cycle, drop grant, emit no done_stb, update last_owner; abort in DUMP or IDLE SHALL be ignored.
REQ-026 abort and the final sample_vld in the same cycle: abort SHALL win.
REQ-027 result_ack outside DUMP SHALL be ignored.
REQ-028 With a single persistent requester the scheduler SHALL re-grant it back-to-back.

Reset
REQ-029 rst SHALL asynchronously force IDLE, grant=0, corr_rst=0, corr_en=0, done_stb=0, done_id=0, busy=0, counter=0, last_owner=N_REQ-1 (so requester 0 has first priority).
REQ-030 rst asserted mid-window SHALL discard the window; after rst release the first granted window SHALL begin with a CLEAR pulse.

Structure
REQ-031 A shared package SHALL hold the state enumeration, LEN_W and the default window constant 13'h0800.
REQ-032 The round-robin arbiter SHALL be a sub-module rr_arbiter (req, last_owner -> one-hot grant); the FSM and counter remain in correlator_scheduler.

Verification
REQ-033 Reset then req=4'b0001, win_len=0, sample_vld=1 continuously -> grant=0001, one corr_rst cycle, corr_en high 2048 cycles, done_stb with done_id=0.
REQ-034 req=4'b1111 held, win_len=4, result_ack one cycle after each done -> grants 0001,0010,0100,1000,0001 in order.
REQ-035 win_len=3, sample_vld toggling 1,0,1,0,1 -> DUMP entered the cycle after the 3rd valid.
REQ-036 abort on cycle 2 of RUN -> IDLE next cycle, no done_stb, next grant goes to following requester.
REQ-037 done_stb held 10 cycles without result_ack -> grant and done_id stable; ack -> IDLE next cycle.
REQ-038 rst pulsed mid-RUN with req held -> all outputs zero asynchronously; after release grant to requester 0 preceded by corr_rst.
